// File: rtl/serial_subtractor.sv
// Bit-serial subtractor s = a - b, LSB-first, one bit per clock with a start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_FLAGS_EN to add registered zero/neg/ovf result flags.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, s_q, s_d;
    logic [CW-1:0]    cnt_q;
    logic             brw_q, brw_d, borrow_q;
    logic             x, y, d, accept, last;

    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    // One full-subtract cell on the current LSBs.
    assign x     = a_sh_q[0];
    assign y     = b_sh_q[0];
    assign d     = x ^ y ^ brw_q;
    assign brw_d = (~x & y) | (~(x ^ y) & brw_q);
    assign s_d   = {d, s_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            s_q      <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else if (state_q == RUN) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            s_q    <= s_d;
            cnt_q  <= cnt_q + 1'b1;
            brw_q  <= brw_d;
            if (last) borrow_q <= brw_d;
        end
    end

    assign s      = s_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic a_msb_q, b_msb_q, zero_q, neg_q, ovf_q;

    // Flags are taken from the final shift value so they land together with s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (last) begin
            zero_q <= (s_d == '0);
            neg_q  <= d;
            ovf_q  <= (a_msb_q != b_msb_q) && (d != a_msb_q);
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor with a cycle-level behavioural model and literal pins.
module tb_serial_subtractor;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] s;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic         zero, neg, ovf;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .borrow(borrow)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        , .zero(zero), .neg(neg), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // since = edges elapsed since the accepting edge (-1: nothing accepted yet).
    logic         p_start, p_rst;
    logic [W-1:0] p_a, p_b;
    int           since = -1;
    logic [W-1:0] pend_s, out_s;
    logic         pend_b, out_b;
    logic [2:0]   pend_f, out_f;

    always @(posedge clk) begin
        p_start = start;
        p_rst   = rst;
        p_a     = a;
        p_b     = b;
    end

    always @(negedge clk) begin
        logic [W-1:0] r;
        if (rst || p_rst) begin
            since = -1;
            out_s = '0; out_b = 1'b0; out_f = '0;
        end else if (p_start && !(since >= 0 && since < W)) begin
            since  = 0;
            r      = p_a - p_b;
            pend_s = r;
            pend_b = (p_a < p_b);
            pend_f = {(r == '0), r[W-1], (p_a[W-1] != p_b[W-1]) && (r[W-1] != p_a[W-1])};
            out_s  = '0; out_b = 1'b0; out_f = '0;
        end else if (since >= 0 && since < 1000000) begin
            since++;
            if (since == W) begin
                out_s = pend_s; out_b = pend_b; out_f = pend_f;
            end
        end
        cmp("busy", W'(busy), W'(since >= 0 && since < W));
        cmp("done", W'(done), W'(since == W));
        if (!(since >= 0 && since < W)) begin
            cmp("s", s, out_s);
            cmp("borrow", W'(borrow), W'(out_b));
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            cmp("flags", W'({zero, neg, ovf}), W'(out_f));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(posedge clk); #2;
        start = 1'b1; a = ia; b = ib;
        @(posedge clk); #2;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
    endtask

    task automatic wait_done(output int nbusy);
        bit seen = 0;
        nbusy = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #1;
            if (busy) nbusy++;
            if (done) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no done pulse within 40 cycles at %0t", $time);
        end
    endtask

    task automatic check_res(input string name, input logic [W-1:0] es, input logic eb,
                             input logic [2:0] ef);
        cmp({name, "_s"}, s, es);
        cmp({name, "_borrow"}, W'(borrow), W'(eb));
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        cmp({name, "_flags"}, W'({zero, neg, ovf}), W'(ef));
`else
        if (ef === 3'bxxx) $display("unused flags");
`endif
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] es, input logic eb, input logic [2:0] ef);
        int nb;
        go(ia, ib);
        wait_done(nb);
        cmp({name, "_busycycles"}, W'(nb), W'(16));
        check_res(name, es, eb, ef);
    endtask

    initial begin
        int nb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        cmp("reset_busy", W'(busy), '0);
        cmp("reset_done", W'(done), '0);
        cmp("reset_s", s, '0);
        cmp("reset_borrow", W'(borrow), '0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // flags order: {zero, neg, ovf}
        run_op("t1", 16'd5, 16'd3, 16'h0002, 1'b0, 3'b000);
        run_op("t2a", 16'd3, 16'd5, 16'hFFFE, 1'b1, 3'b010);
        run_op("t2b", 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b100);
        run_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 3'b001);
        run_op("t3b", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3'b010);

        // start while busy is ignored
        go(16'd9, 16'd4);
        repeat (4) @(posedge clk);
        #2 start = 1'b1; a = 16'd1; b = 16'd1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(nb);
        check_res("t4", 16'h0005, 1'b0, 3'b000);

        // back-to-back start in the DONE cycle
        go(16'd20, 16'd2);
        wait_done(nb);
        start = 1'b1; a = 16'd7; b = 16'd7;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        cmp("t5_nogap_busy", W'(busy), W'(1));
        wait_done(nb);
        cmp("t5_busycycles", W'(nb), W'(15));
        check_res("t5", 16'h0000, 1'b0, 3'b100);

        // reset mid-operation
        go(16'd100, 16'd1);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp("t6_busy", W'(busy), '0);
        cmp("t6_done", W'(done), '0);
        cmp("t6_s", s, '0);
        cmp("t6_borrow", W'(borrow), '0);
        @(posedge clk); #2 rst = 1'b0;
        run_op("t6b", 16'd100, 16'd1, 16'd99, 1'b0, 3'b000);

        // random traffic: frequent starts, stray starts while busy, rare resets
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
        end
        @(posedge clk); #2 rst = 1'b0; start = 1'b0;
        repeat (25) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
